vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl_if.sv | 26 ++
 rtl/vga_timing_ctrl.sv | 123 ++++++++++++
 tb/tb_vga_timing_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_if.sv
// Bundle between the VGA timing generator and its controller: run control,
// mode-configuration handshake and the decoded scan outputs.
interface vga_timing_ctrl_if;
  logic       run;
  logic       cfg_valid;
  logic [3:0] cfg_data;
  logic       cfg_ready;
  logic [3:0] mode;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output run, cfg_valid, cfg_data,
    input  cfg_ready, mode, hpos, vpos, hsync, vsync, display_on, frame_start, frame_cnt
  );

  modport slave (
    input  run, cfg_valid, cfg_data,
    output cfg_ready, mode, hpos, vpos, hsync, vsync, display_on, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with frame-synchronous mode update; all scan outputs are
// registered and decoded from the next position, so they share the hpos/vpos cycle.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_ctrl_if.slave  bus
);
  localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       active_q, active_d;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] mode_q, mode_d;
  logic [3:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       wrap;

  // active_q marks that the previous cycle was scanning; its absence makes the
  // first running edge land on (0,0) rather than advancing.
  always_comb begin
    active_d    = bus.run;
    hpos_d      = '0;
    vpos_d      = '0;
    wrap        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;

    if (bus.run && active_q) begin
      if (hpos_q == H_MAX) begin
        hpos_d = '0;
        if (vpos_q == V_MAX) begin
          vpos_d = '0;
          wrap   = 1'b1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
      end
    end

    hsync_d = !(bus.run && (hpos_d >= HS_BEG) && (hpos_d <= HS_END));
    vsync_d = !(bus.run && (vpos_d >= VS_BEG) && (vpos_d <= VS_END));
    de_d    = bus.run && (hpos_d < H_ACT) && (vpos_d < V_ACT);
    fs_d    = bus.run && (hpos_d == '0) && (vpos_d == '0);

    if (wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (pend_vld_q) begin
        mode_d     = pend_q;
        pend_vld_d = 1'b0;
      end
    end

    // Ready is !pend_vld_q, so a capture can never collide with the apply above.
    if (bus.cfg_valid && !pend_vld_q) begin
      pend_d     = bus.cfg_data;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q    <= 1'b0;
      hpos_q      <= '0;
      vpos_q      <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      active_q    <= active_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.display_on  = de_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.mode        = mode_q;
  assign bus.cfg_ready   = !pend_vld_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a full-size instance for 640x480 edge decode, and a shrunken
// instance (32x20 total, 640-cycle frames) for frame-level mode/run/reset behaviour.
module tb_vga_timing_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  vga_timing_ctrl_if f_if ();
  vga_timing_ctrl_if s_if ();

  vga_timing_ctrl u_full (
    .clk (clk),
    .rst (rst),
    .bus (f_if)
  );

  // Small geometry: hsync low at h 20..25, vsync low at v 14..15, active 16x12.
  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hs_lo, vs_lo, de_hi, fs_hi;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    f_if.run = 1'b1;
    f_if.cfg_valid = 1'b0;
    f_if.cfg_data = 4'h0;
    s_if.run = 1'b0;
    s_if.cfg_valid = 1'b0;
    s_if.cfg_data = 4'h0;

    tick(2);
    chk("rst_hpos", f_if.hpos, 0);
    chk("rst_vpos", f_if.vpos, 0);
    chk("rst_hsync", f_if.hsync, 1);
    chk("rst_vsync", f_if.vsync, 1);
    chk("rst_de", f_if.display_on, 0);
    chk("rst_fs", f_if.frame_start, 0);
    chk("rst_fcnt", f_if.frame_cnt, 0);
    chk("rst_mode", f_if.mode, 0);
    chk("rst_ready", f_if.cfg_ready, 1);

    // Full-size edge decode
    rst = 1'b0;
    tick(1);
    chk("first_fs", f_if.frame_start, 1);
    chk("first_pos", {f_if.hpos, f_if.vpos}, {10'd0, 10'd0});
    chk("first_de", f_if.display_on, 1);
    tick(639);
    chk("h639_pos", f_if.hpos, 639);
    chk("h639_de", f_if.display_on, 1);
    chk("h639_fs", f_if.frame_start, 0);
    tick(1);
    chk("h640_de", f_if.display_on, 0);
    tick(4015);
    chk("h655_pos", {f_if.hpos, f_if.vpos}, {10'd655, 10'd5});
    chk("h655_hs", f_if.hsync, 1);
    tick(1);
    chk("h656_hs", f_if.hsync, 0);
    tick(95);
    chk("h751_hs", f_if.hsync, 0);
    tick(1);
    chk("h752_hs", f_if.hsync, 1);
    chk("h752_vs", f_if.vsync, 1);
    hs_lo = 0;
    for (int i = 0; i < 800; i++) begin
      if (!f_if.hsync) hs_lo++;
      tick(1);
    end
    chk("line_hs_low", hs_lo, 96);

    // Small instance: one full frame of counts from a run 0->1 restart
    s_if.run = 1'b1;
    tick(1);
    chk("s_start_fs", s_if.frame_start, 1);
    hs_lo = 0; vs_lo = 0; de_hi = 0; fs_hi = 0;
    for (int i = 0; i < 640; i++) begin
      if (!s_if.hsync) hs_lo++;
      if (!s_if.vsync) vs_lo++;
      if (s_if.display_on) de_hi++;
      if (s_if.frame_start) fs_hi++;
      if (i == 15) chk("s_de_15_0", s_if.display_on, 1);
      if (i == 16) chk("s_de_16_0", s_if.display_on, 0);
      if (i == 384) chk("s_de_0_12", s_if.display_on, 0);
      tick(1);
    end
    chk("s_hs_low", hs_lo, 120);
    chk("s_vs_low", vs_lo, 64);
    chk("s_de_hi", de_hi, 192);
    chk("s_fs_hi", fs_hi, 1);
    chk("s_wrap_fcnt", s_if.frame_cnt, 1);
    chk("s_wrap_fs", s_if.frame_start, 1);

    // Mid-frame config 5, then an ignored 9 while pending
    tick(100);
    chk("cfg_rdy_before", s_if.cfg_ready, 1);
    s_if.cfg_valid = 1'b1;
    s_if.cfg_data = 4'h5;
    tick(1);
    chk("cfg_rdy_drop", s_if.cfg_ready, 0);
    chk("cfg_mode_hold", s_if.mode, 0);
    s_if.cfg_data = 4'h9;
    tick(3);
    s_if.cfg_valid = 1'b0;
    tick(535);
    chk("pre_wrap_pos", {s_if.hpos, s_if.vpos}, {10'd31, 10'd19});
    chk("pre_wrap_mode", s_if.mode, 0);
    tick(1);
    chk("apply_fs", s_if.frame_start, 1);
    chk("apply_mode", s_if.mode, 5);
    chk("apply_ready", s_if.cfg_ready, 1);
    chk("apply_fcnt", s_if.frame_cnt, 2);

    // Transfer on the wrap cycle itself waits a whole frame
    tick(639);
    s_if.cfg_valid = 1'b1;
    s_if.cfg_data = 4'hA;
    tick(1);
    s_if.cfg_valid = 1'b0;
    chk("wrapxfer_mode", s_if.mode, 5);
    chk("wrapxfer_ready", s_if.cfg_ready, 0);
    chk("wrapxfer_fcnt", s_if.frame_cnt, 3);
    tick(639);
    chk("wrapxfer_hold", s_if.mode, 5);
    tick(1);
    chk("wrapxfer_apply", s_if.mode, 4'hA);
    chk("wrapxfer_fcnt2", s_if.frame_cnt, 4);

    // Run dropped mid-frame; handshake still accepted while idle
    tick(300);
    chk("drop_pos", {s_if.hpos, s_if.vpos}, {10'd12, 10'd9});
    s_if.run = 1'b0;
    s_if.cfg_valid = 1'b1;
    s_if.cfg_data = 4'h3;
    tick(1);
    s_if.cfg_valid = 1'b0;
    chk("idle_pos", {s_if.hpos, s_if.vpos}, 0);
    chk("idle_flags", {s_if.hsync, s_if.vsync, s_if.display_on, s_if.frame_start}, 4'b1100);
    chk("idle_ready", s_if.cfg_ready, 0);
    tick(9);
    chk("idle_fcnt", s_if.frame_cnt, 4);
    chk("idle_mode", s_if.mode, 4'hA);
    s_if.run = 1'b1;
    tick(1);
    chk("rerun_fs", s_if.frame_start, 1);
    chk("rerun_pos", {s_if.hpos, s_if.vpos}, 0);
    chk("rerun_fcnt", s_if.frame_cnt, 4);
    chk("rerun_mode", s_if.mode, 4'hA);

    // Asynchronous reset mid-frame, sampled before any clock edge
    tick(50);
    rst = 1'b1;
    #2;
    chk("arst_pos", {s_if.hpos, s_if.vpos}, 0);
    chk("arst_flags", {s_if.hsync, s_if.vsync, s_if.display_on, s_if.frame_start}, 4'b1100);
    chk("arst_fcnt", s_if.frame_cnt, 0);
    chk("arst_mode", s_if.mode, 0);
    chk("arst_ready", s_if.cfg_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    chk("post_rst_fs", s_if.frame_start, 1);
    chk("post_rst_pos", {s_if.hpos, s_if.vpos}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
